// File: rtl/uart_stream_rx.sv
// 8N1 UART receiver feeding a small FIFO that drives an 8-bit valid/ready/last byte stream.
// Optional stop-bit framing check enabled by defining UART_STREAM_RX_FRAMING_CHECK_EN.
module uart_stream_rx #(
  parameter int CLK_FREQ = 16000000,
  parameter int BAUD     = 57600,
  parameter int DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_overrun,
  output logic       o_frame_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIV);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic          rxMeta_q, rxSync_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          expired;
  logic          stopSample;
  logic          pushReq;

  logic [8:0]    mem_q [DEPTH];
  logic [AW:0]   wPtr_q, rPtr_q;
  logic          empty, full, pop, push;
  logic          overrun_q;
  logic [8:0]    head;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= i_uart_rx;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  // The counter counts down to 1; the sample is taken in the cycle it reads 1.
  assign expired = (cnt_q == CW'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    stopSample = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxSync_q) begin
          cnt_d   = HALF_CNT;
          state_d = START;
        end
      end
      START: begin
        if (expired) begin
          if (rxSync_q) begin
            state_d = IDLE;
          end else begin
            cnt_d    = FULL_CNT;
            bitIdx_d = '0;
            state_d  = DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (expired) begin
          shift_d = {rxSync_q, shift_q[7:1]};
          cnt_d   = FULL_CNT;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (expired) begin
          stopSample = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_STREAM_RX_FRAMING_CHECK_EN
  logic frameErr_q;

  assign pushReq = stopSample & rxSync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frameErr_q <= 1'b0;
    end else begin
      frameErr_q <= stopSample & ~rxSync_q;
    end
  end

  assign o_frame_err = frameErr_q;
`else
  assign pushReq     = stopSample;
  assign o_frame_err = 1'b0;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wPtr_q == rPtr_q);
  assign full  = (wPtr_q[AW] != rPtr_q[AW]) && (wPtr_q[AW-1:0] == rPtr_q[AW-1:0]);
  assign pop   = o_tvalid & i_tready;
  assign push  = pushReq & (~full | pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wPtr_q    <= '0;
      rPtr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= pushReq & full & ~pop;
      if (push) begin
        wPtr_q <= wPtr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rPtr_q <= rPtr_q + (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wPtr_q[AW-1:0]] <= {(shift_q == 8'h0A), shift_q};
    end
  end

  // Masking with empty keeps the stream outputs at 0 after reset regardless of stale storage.
  assign head      = mem_q[rPtr_q[AW-1:0]];
  assign o_tvalid  = ~empty;
  assign o_tdata   = empty ? 8'h00 : head[7:0];
  assign o_tlast   = ~empty & head[8];
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_stream_rx.sv
// Self-checking bench for uart_stream_rx: directed scenarios plus random bytes with random back-pressure,
// compared against a queue-based model of the expected byte stream.
module tb_uart_stream_rx;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  // Pin driven at a negedge: the stop sample lands on the 155th following posedge.
  localparam int STOP_LAT = 155;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tready = 1'b1;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       overrun;
  logic       frameErr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] gotQ[$];
  logic [8:0] expQ[$];
  int overrunCnt = 0;
  int frameCnt = 0;
  int lastOverrunCyc = 0;
  int lastFrameCyc = 0;
  int riseCyc = -1;
  logic prevValid = 1'b0;
  logic prevHold = 1'b0;
  logic [8:0] prevBeat = '0;
  logic randDone = 1'b0;

  uart_stream_rx #(
    .CLK_FREQ(16000000),
    .BAUD    (1000000),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_tdata    (tdata),
    .o_tlast    (tlast),
    .o_tvalid   (tvalid),
    .i_tready   (tready),
    .o_overrun  (overrun),
    .o_frame_err(frameErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame; must be entered at a negedge and returns at a negedge.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stopBit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic logic [8:0] beatAt(input int i);
    if (gotQ.size() > i) return gotQ[i];
    return 9'bx;
  endfunction

  function automatic logic [8:0] modelBeat(input logic [7:0] b);
    return {(b == 8'h0A), b};
  endfunction

  task automatic clearScore();
    gotQ.delete();
    expQ.delete();
    overrunCnt = 0;
    frameCnt = 0;
    riseCyc = -1;
  endtask

  task automatic compareQueues(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("%s_beat%0d", tag, i), {23'd0, beatAt(i)}, {23'd0, expQ[i]});
    end
  endtask

  // Monitor: collects accepted beats, counts pulses and checks head stability under back-pressure.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prevValid = 1'b0;
      prevHold  = 1'b0;
    end else begin
      if (tvalid && !prevValid) riseCyc = cyc;
      if (prevHold) checkOutput("holdStable", {23'd0, tvalid, tlast, tdata}, {23'd0, 1'b1, prevBeat});
      if (tvalid && tready) gotQ.push_back({tlast, tdata});
      if (overrun) begin
        overrunCnt++;
        lastOverrunCyc = cyc;
      end
      if (frameErr) begin
        frameCnt++;
        lastFrameCyc = cyc;
      end
      prevValid = tvalid;
      prevHold  = tvalid && !tready;
      prevBeat  = {tlast, tdata};
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    int n;
    logic [7:0] b;
    logic [7:0] sent[$];

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {21'd0, tvalid, tlast, tdata, overrun, frameErr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain byte, valid latency
    clearScore();
    s = cyc;
    applyStimulus(8'h55, 1'b1);
    expQ.push_back(modelBeat(8'h55));
    repeat (20) @(negedge clk);
    compareQueues("byte55");
    checkOutput("byte55_validRise", riseCyc - s, STOP_LAT);
    checkOutput("byte55_pulses", overrunCnt + frameCnt, 0);

    // Newline sets last
    clearScore();
    applyStimulus(8'h0A, 1'b1);
    expQ.push_back(modelBeat(8'h0A));
    repeat (20) @(negedge clk);
    compareQueues("byte0A");

    // False start, then a real byte proves the receiver is idle again
    clearScore();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    checkOutput("falseStart_beats", gotQ.size(), 0);
    checkOutput("falseStart_pulses", overrunCnt + frameCnt, 0);
    applyStimulus(8'h5A, 1'b1);
    expQ.push_back(modelBeat(8'h5A));
    repeat (20) @(negedge clk);
    compareQueues("afterFalseStart");

    // Overrun: five back-to-back bytes into a stalled FIFO
    clearScore();
    tready = 1'b0;
    sent.delete();
    s = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) s = cyc;
      applyStimulus(8'(k), 1'b1);
      sent.push_back(8'(k));
    end
    repeat (20) @(negedge clk);
    n = sent.size();
    for (int i = 0; i < n && i < DEPTH; i++) expQ.push_back(modelBeat(sent[i]));
    checkOutput("overrun_count", overrunCnt, (n > DEPTH) ? n - DEPTH : 0);
    checkOutput("overrun_timing", lastOverrunCyc - s, STOP_LAT);
    checkOutput("overrun_headHeld", {23'd0, tvalid, tlast, tdata}, {23'd0, 1'b1, expQ[0]});
    tready = 1'b1;
    repeat (10) @(negedge clk);
    compareQueues("overrunDrain");
    checkOutput("overrun_validDrops", {31'd0, tvalid}, 32'd0);

    // Bad stop bit
    clearScore();
    s = cyc;
    applyStimulus(8'hA5, 1'b0);
    repeat (30) @(negedge clk);
`ifdef UART_STREAM_RX_FRAMING_CHECK_EN
    checkOutput("frame_count", frameCnt, 1);
    checkOutput("frame_timing", lastFrameCyc - s, STOP_LAT);
`else
    expQ.push_back(modelBeat(8'hA5));
    checkOutput("frame_count", frameCnt, 0);
`endif
    compareQueues("badStop");
    checkOutput("frame_noOverrun", overrunCnt, 0);

    // Reset in the middle of bit 4 with a byte already queued
    clearScore();
    tready = 1'b0;
    applyStimulus(8'h77, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("preReset_valid", {31'd0, tvalid}, 32'd1);
    b = {4'hF, 4'($urandom_range(0, 15))};
    fork
      applyStimulus(b, 1'b1);
      begin
        repeat (5 * DIV + 4) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("midReset_outputs", {21'd0, tvalid, tlast, tdata, overrun, frameErr}, 32'd0);
        rst_n = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    checkOutput("postReset_empty", {31'd0, tvalid}, 32'd0);
    tready = 1'b1;
    clearScore();
    applyStimulus(8'h3C, 1'b1);
    expQ.push_back(modelBeat(8'h3C));
    repeat (20) @(negedge clk);
    compareQueues("afterReset");

    // Random bytes under random back-pressure; throughput never fills the FIFO
    clearScore();
    randDone = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          b = 8'($urandom);
          expQ.push_back(modelBeat(b));
          applyStimulus(b, 1'b1);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          tready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    tready = 1'b1;
    repeat (20) @(negedge clk);
    compareQueues("random");
    checkOutput("random_noOverrun", overrunCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_stream_rx.md
# uart_stream_rx

Receive-side counterpart of the corescore byte emitter. Deserialises an 8N1 UART line into bytes and presents them on the same 8-bit valid/ready/last byte-stream interface that `corescorecore` drives into the emitter. A small FIFO absorbs back-pressure. It sits between a board's UART RX pin and any stream consumer, for example a command sink or a loopback path.

## Interface
Parameters:
- `CLK_FREQ`, default 16000000: `i_clk` frequency in Hz.
- `BAUD`, default 57600: line rate. `DIV = CLK_FREQ/BAUD`, truncated; `DIV >= 4` is required.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, minimum 2.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `i_uart_rx`, in, 1: serial line. Asynchronous to `i_clk`; idle high.
- `o_tdata`, out, 8: received byte.
- `o_tlast`, out, 1: high with a byte equal to 8'h0A.
- `o_tvalid`, out, 1: a byte is available.
- `i_tready`, in, 1: consumer accepts the byte.
- `o_overrun`, out, 1: one-cycle pulse when a byte is dropped because the FIFO is full.
- `o_frame_err`, out, 1: one-cycle pulse when a stop bit is bad. Tied 0 when the framing check is compiled out.

## Operation
- **Synchroniser:** `i_uart_rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- **Receive state machine (IDLE, START, DATA, STOP):**
  - IDLE: a low on the synchronised line loads the bit counter with `DIV/2` and moves to START.
  - START: at counter expiry, sample the line. If high, it was a false start: return to IDLE. If low, reload with `DIV` and go to DATA with bit index 0.
  - DATA: at each expiry, sample into the shift register LSB-first, then reload `DIV`. After bit 7, go to STOP.
  - STOP: at expiry, sample the stop bit, attempt the FIFO push, and return to IDLE the same cycle. The next start edge may therefore arrive from half a bit later.
- **FIFO:**
  - Each entry is 9 bits: the data byte plus a last flag computed at push as `byte == 8'h0A`.
  - `o_tvalid` = FIFO not empty. `o_tdata` and `o_tlast` show the head entry.
  - A pop occurs on `o_tvalid && i_tready`.
- **Push rules:**
  - Push when not full. Also push when full if a pop happens in the same cycle; that push is accepted.
  - If full and no pop, discard the byte and pulse `o_overrun`. FIFO contents are unchanged.
- **Stream rule:** `o_tdata`/`o_tlast` stay stable while `o_tvalid && !i_tready`.
- **Reset (any time, including mid-byte):**
  - State machine returns to IDLE; counters and shift register clear.
  - FIFO empties.
  - All outputs go to 0, except that the synchroniser flops go to 1.

## Timing
- Define cycle 0 as the first cycle the synchronised line is seen low in IDLE. This is 2–3 cycles after the pin edge.
- Start bit is sampled at cycle `DIV/2`. Data bit n (n = 0..7) is sampled at `DIV/2 + (n+1)*DIV`. The stop bit is sampled at `DIV/2 + 9*DIV`.
- The FIFO write happens on the stop-sample edge. `o_tvalid` is high from the next cycle when the FIFO was empty.
- `o_overrun` and `o_frame_err` are registered and high for exactly the one cycle after the stop sample.
- Throughput: one byte per `10*DIV` cycles, sustained with no drops while `i_tready` stays high.

## Configuration
- Macro: `UART_STREAM_RX_FRAMING_CHECK_EN`.
- **Defined:** a stop bit sampled low discards the byte (no push, no overrun) and pulses `o_frame_err`.
- **Not defined:** the stop-bit value is ignored, every byte is pushed, and `o_frame_err` is constant 0.

## Test plan
All scenarios use `CLK_FREQ=16000000`, `BAUD=1000000` (so `DIV=16`) and `DEPTH=4`.
- Send 8'h55 with `i_tready=1`: one beat with `o_tdata=8'h55`, `o_tlast=0`. `o_tvalid` rises 1 cycle after the stop-sample edge.
- Send 8'h0A: one beat with `o_tdata=8'h0A`, `o_tlast=1`.
- Drive the line low for 4 cycles, then high: false start detected, no beat, no error pulses, state machine back in IDLE.
- Hold `i_tready=0` and send 8'h01..8'h05 back-to-back: a single `o_overrun` pulse on byte 5. Raising `i_tready` then yields 01, 02, 03, 04, and `o_tvalid` drops after 04.
- Send 8'hA5 with the stop bit held low:
  - Macro defined: no beat, one `o_frame_err` pulse.
  - Macro undefined: beat 8'hA5 delivered, `o_frame_err` stays 0.
- Assert `i_rst_n=0` for 3 cycles in the middle of bit 4 of a byte: all outputs 0 and FIFO empty. A following 8'h3C is received correctly.
